// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the cpu_wide core.
//   * FSM state encoding (4-bit, legacy-compatible localparams)
//   * opcode constants for 1-word (bit7=0) and 2-word (bit7=1) instructions
//   * bit positions of the Z and C flags inside the flags register
// -----------------------------------------------------------------------------
package cpu_pkg;

   // FSM states
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_WAIT    = 4'd2;
   localparam logic [3:0] S_OPLOAD  = 4'd3;
   localparam logic [3:0] S_DECODE  = 4'd4;
   localparam logic [3:0] S_WAIT2   = 4'd5;
   localparam logic [3:0] S_OPLOAD2 = 4'd6;
   localparam logic [3:0] S_DECODE2 = 4'd7;
   localparam logic [3:0] S_WAIT3   = 4'd8;
   localparam logic [3:0] S_MEMLOAD = 4'd9;
   localparam logic [3:0] S_ECHO    = 4'd10;
   localparam logic [3:0] S_READ    = 4'd11;

   // 1-word opcodes
   localparam logic [7:0] OP_HLT   = 8'h00;
   localparam logic [7:0] OP_OUTA  = 8'h01;
   localparam logic [7:0] OP_INA   = 8'h02;
   localparam logic [7:0] OP_CLF   = 8'h03;
   localparam logic [7:0] OP_ADD   = 8'h04;
   localparam logic [7:0] OP_SUB   = 8'h05;
   localparam logic [7:0] OP_RTS   = 8'h06;

   // 2-word opcodes (operand word follows the opcode)
   localparam logic [7:0] OP_LDA_I = 8'h80;
   localparam logic [7:0] OP_LDB_I = 8'h81;
   localparam logic [7:0] OP_LDA_M = 8'h84;
   localparam logic [7:0] OP_STA_M = 8'h88;
   localparam logic [7:0] OP_BRA   = 8'h90;
   localparam logic [7:0] OP_BRZ   = 8'h91;
   localparam logic [7:0] OP_BRC   = 8'h92;
   localparam logic [7:0] OP_JSR   = 8'h94;

   // flag bit indices
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;

endpackage

// File: rtl/alu_wide.sv
// -----------------------------------------------------------------------------
// alu_wide -- DW-bit add/subtract with carry (borrow) in and out.
//   a_i, b_i  : operands
//   sub_i     : 0 = a+b+c_i, 1 = a-b-c_i
//   c_i       : carry in (borrow in for subtract)
//   y_o       : DW-bit result
//   c_o       : carry out (borrow out for subtract)
//   z_o       : y_o == 0
// -----------------------------------------------------------------------------
module alu_wide #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic          sub_i,
   input  logic          c_i,
   output logic [DW-1:0] y_o,
   output logic          c_o,
   output logic          z_o
);

   logic [DW:0] res;

   // Computed one bit wider; for subtract the top bit goes high exactly when
   // the result underflows, which is the borrow.
   always_comb begin
      if (sub_i) res = {1'b0, a_i} - {1'b0, b_i} - {{DW{1'b0}}, c_i};
      else       res = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, c_i};
   end

   assign y_o = res[DW-1:0];
   assign c_o = res[DW];
   assign z_o = (res[DW-1:0] == '0);

endmodule

// File: rtl/cpu_wide.sv
// -----------------------------------------------------------------------------
// cpu_wide -- small multi-cycle accumulator CPU with UART hooks.
//   clk, rst          : clock, synchronous active-low reset
//   start, startaddr  : leave IDLE and run from startaddr
//   c_raddr, dread    : memory read port (data sampled two edges after addr)
//   c_waddr, dwrite,
//   write_en          : memory write port, one-cycle strobe
//   tx_byte, transmit,
//   is_transmitting   : UART transmit
//   rx_byte, received : UART receive
//   halted, fault     : one-cycle pulses on HLT / stack error
// Optional feature: define CPU_WIDE_STACK_EN for the JSR/RTS return stack;
// without it, 06/94 are NOPs (94 still consumes its operand) and fault is 0.
// -----------------------------------------------------------------------------
module cpu_wide
   import cpu_pkg::*;
#(
   parameter int DW          = 8,
   parameter int AW          = 9,
   parameter int STACK_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] startaddr,
   output logic [AW-1:0] c_raddr,
   input  logic [DW-1:0] dread,
   output logic [AW-1:0] c_waddr,
   output logic [DW-1:0] dwrite,
   output logic          write_en,
   output logic [7:0]    tx_byte,
   output logic          transmit,
   input  logic          is_transmitting,
   input  logic [7:0]    rx_byte,
   input  logic          received,
   output logic          halted,
   output logic          fault
);

   logic [3:0]    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] a_q, a_d, b_q, b_d;
   logic [1:0]    flags_q, flags_d;
   logic [7:0]    opcode_q, opcode_d;
   logic [DW-1:0] operand_q, operand_d;
   logic [AW-1:0] c_raddr_q, c_raddr_d, c_waddr_q, c_waddr_d;
   logic [DW-1:0] dwrite_q, dwrite_d;
   logic          write_en_q, write_en_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          transmit_q, transmit_d;
   logic          halted_q, halted_d;

   // operand as memory address (zero-extended) and branch offset (sign-extended)
   logic [AW-1:0] mem_addr, br_off, br_tgt;

   generate
      if (DW >= AW) begin : g_opnd_wide
         assign mem_addr = operand_q[AW-1:0];
         assign br_off   = operand_q[AW-1:0];
      end else begin : g_opnd_narrow
         assign mem_addr = {{(AW-DW){1'b0}}, operand_q};
         assign br_off   = {{(AW-DW){operand_q[DW-1]}}, operand_q};
      end
   endgenerate

   // pc already points past the operand when this is used
   assign br_tgt = pc_q + br_off;

   logic [DW-1:0] alu_y;
   logic          alu_c, alu_z;

   alu_wide #(.DW(DW)) u_alu (
      .a_i   (a_q),
      .b_i   (b_q),
      .sub_i (opcode_q == OP_SUB),
      .c_i   (flags_q[FLAG_C]),
      .y_o   (alu_y),
      .c_o   (alu_c),
      .z_o   (alu_z)
   );

`ifdef CPU_WIDE_STACK_EN
   localparam int SPW = $clog2(STACK_DEPTH) + 1;

   logic [SPW-1:0] sp_q, sp_d;
   logic           fault_q, fault_d;
   logic           stk_push;
   logic [AW-1:0]  stk_q [STACK_DEPTH];
   logic [SPW-2:0] pop_idx;

   assign pop_idx = (SPW-1)'(sp_q - SPW'(1));

   // Return stack storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (rst && stk_push) stk_q[sp_q[SPW-2:0]] <= pc_q;
   end
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      a_d        = a_q;
      b_d        = b_q;
      flags_d    = flags_q;
      opcode_d   = opcode_q;
      operand_d  = operand_q;
      c_raddr_d  = c_raddr_q;
      c_waddr_d  = c_waddr_q;
      dwrite_d   = dwrite_q;
      tx_byte_d  = tx_byte_q;
      write_en_d = 1'b0;
      transmit_d = 1'b0;
      halted_d   = 1'b0;
`ifdef CPU_WIDE_STACK_EN
      sp_d       = sp_q;
      fault_d    = 1'b0;
      stk_push   = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = startaddr;
`ifdef CPU_WIDE_STACK_EN
               sp_d    = '0;
`endif
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            c_raddr_d = pc_q;
            state_d   = S_WAIT;
         end

         S_WAIT: state_d = S_OPLOAD;

         S_OPLOAD: begin
            opcode_d = dread[7:0];
            pc_d     = pc_q + AW'(1);
            state_d  = S_DECODE;
         end

         S_DECODE: begin
            if (opcode_q[7]) begin
               // fetch the operand word at pc
               c_raddr_d = pc_q;
               state_d   = S_WAIT2;
            end else begin
               state_d = S_FETCH;
               case (opcode_q)
                  OP_HLT: begin
                     halted_d = 1'b1;
                     state_d  = S_IDLE;
                  end
                  OP_OUTA: state_d = S_ECHO;
                  OP_INA:  state_d = S_READ;
                  OP_CLF:  flags_d = '0;
                  OP_ADD, OP_SUB: begin
                     a_d             = alu_y;
                     flags_d[FLAG_C] = alu_c;
                     flags_d[FLAG_Z] = alu_z;
                  end
`ifdef CPU_WIDE_STACK_EN
                  OP_RTS: begin
                     if (sp_q == '0) begin
                        fault_d = 1'b1;
                        state_d = S_IDLE;
                     end else begin
                        pc_d = stk_q[pop_idx];
                        sp_d = sp_q - SPW'(1);
                     end
                  end
`endif
                  default: ;
               endcase
            end
         end

         S_WAIT2: state_d = S_OPLOAD2;

         S_OPLOAD2: begin
            operand_d = dread;
            pc_d      = pc_q + AW'(1);
            state_d   = S_DECODE2;
         end

         S_DECODE2: begin
            state_d = S_FETCH;
            case (opcode_q)
               OP_LDA_I: a_d = operand_q;
               OP_LDB_I: b_d = operand_q;
               OP_LDA_M: begin
                  c_raddr_d = mem_addr;
                  state_d   = S_WAIT3;
               end
               OP_STA_M: begin
                  c_waddr_d  = mem_addr;
                  dwrite_d   = a_q;
                  write_en_d = 1'b1;
               end
               OP_BRA: pc_d = br_tgt;
               OP_BRZ: if (flags_q[FLAG_Z]) pc_d = br_tgt;
               OP_BRC: if (flags_q[FLAG_C]) pc_d = br_tgt;
`ifdef CPU_WIDE_STACK_EN
               OP_JSR: begin
                  if (sp_q == SPW'(STACK_DEPTH)) begin
                     fault_d = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     stk_push = 1'b1;
                     sp_d     = sp_q + SPW'(1);
                     pc_d     = br_tgt;
                  end
               end
`endif
               default: ;
            endcase
         end

         S_WAIT3: state_d = S_MEMLOAD;

         S_MEMLOAD: begin
            a_d     = dread;
            state_d = S_FETCH;
         end

         S_ECHO: begin
            if (!is_transmitting) begin
               tx_byte_d  = a_q[7:0];
               transmit_d = 1'b1;
               state_d    = S_FETCH;
            end
         end

         S_READ: begin
            if (received) begin
               a_d     = DW'(rx_byte);
               state_d = S_FETCH;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         flags_q    <= '0;
         opcode_q   <= '0;
         operand_q  <= '0;
         c_raddr_q  <= '0;
         c_waddr_q  <= '0;
         dwrite_q   <= '0;
         write_en_q <= 1'b0;
         tx_byte_q  <= '0;
         transmit_q <= 1'b0;
         halted_q   <= 1'b0;
`ifdef CPU_WIDE_STACK_EN
         sp_q       <= '0;
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         a_q        <= a_d;
         b_q        <= b_d;
         flags_q    <= flags_d;
         opcode_q   <= opcode_d;
         operand_q  <= operand_d;
         c_raddr_q  <= c_raddr_d;
         c_waddr_q  <= c_waddr_d;
         dwrite_q   <= dwrite_d;
         write_en_q <= write_en_d;
         tx_byte_q  <= tx_byte_d;
         transmit_q <= transmit_d;
         halted_q   <= halted_d;
`ifdef CPU_WIDE_STACK_EN
         sp_q       <= sp_d;
         fault_q    <= fault_d;
`endif
      end
   end

   assign c_raddr  = c_raddr_q;
   assign c_waddr  = c_waddr_q;
   assign dwrite   = dwrite_q;
   assign write_en = write_en_q;
   assign tx_byte  = tx_byte_q;
   assign transmit = transmit_q;
   assign halted   = halted_q;
`ifdef CPU_WIDE_STACK_EN
   assign fault    = fault_q;
`else
   assign fault    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_wide.sv
// -----------------------------------------------------------------------------
// tb_cpu_wide -- scoreboard bench for cpu_wide (DW=8, AW=9).
// Each program run pushes its expected output events (UART tx, memory write,
// halt, fault) into a queue; a negedge monitor pops and compares whenever the
// DUT strobes an output. Memory returns mem[c_raddr] one edge after the
// address register updates, so the CPU samples it two edges after setting it.
// -----------------------------------------------------------------------------
module tb_cpu_wide;

   localparam int DW = 8;
   localparam int AW = 9;
`ifdef CPU_WIDE_STACK_EN
   localparam int SD = 2;
`else
   localparam int SD = 8;
`endif

   localparam logic [1:0] K_TX = 2'd0, K_WR = 2'd1, K_HLT = 2'd2, K_FLT = 2'd3;

   typedef struct packed {
      logic [1:0]    kind;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] startaddr = '0;
   logic [AW-1:0] c_raddr, c_waddr;
   logic [DW-1:0] dread = '0;
   logic [DW-1:0] dwrite;
   logic          write_en, transmit, halted, fault;
   logic [7:0]    tx_byte;
   logic          is_transmitting = 1'b0;
   logic [7:0]    rx_byte = '0;
   logic          received = 1'b0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int   checks = 0, failures = 0, end_cnt = 0, tx_cnt = 0;
   ev_t  exp_q[$];

   always #5 clk = ~clk;

   cpu_wide #(.DW(DW), .AW(AW), .STACK_DEPTH(SD)) dut (
      .clk(clk), .rst(rst), .start(start), .startaddr(startaddr),
      .c_raddr(c_raddr), .dread(dread),
      .c_waddr(c_waddr), .dwrite(dwrite), .write_en(write_en),
      .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
      .rx_byte(rx_byte), .received(received),
      .halted(halted), .fault(fault)
   );

   always @(posedge clk) begin
      dread <= mem[c_raddr];
      if (write_en) mem[c_waddr] <= dwrite;
   end

   function automatic void chk_ev(input ev_t got);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL event_unexpected got=%h required=none", got);
      end else begin
         e = exp_q.pop_front();
         if (e !== got) begin
            failures++;
            $display("FAIL event got=%h required=%h", got, e);
         end
      end
      if (got.kind == K_HLT || got.kind == K_FLT) end_cnt++;
      if (got.kind == K_TX) tx_cnt++;
   endfunction

   // monitor
   always @(negedge clk) begin
      if (rst) begin
         if (write_en) chk_ev({K_WR, c_waddr, dwrite});
         if (transmit) chk_ev({K_TX, {AW{1'b0}}, tx_byte});
         if (halted)   chk_ev({K_HLT, {AW{1'b0}}, 8'h00});
         if (fault)    chk_ev({K_FLT, {AW{1'b0}}, 8'h00});
      end
   end

   function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", nm, got, req);
      end
   endfunction

   function automatic void push(input logic [1:0] k, input logic [AW-1:0] a, input logic [7:0] d);
      exp_q.push_back({k, a, d});
   endfunction

   // load n bytes, first byte in the most significant position of bytes
   task automatic prog(input logic [AW-1:0] a, input int n, input logic [511:0] bytes);
      for (int i = 0; i < n; i++) mem[a + AW'(i)] = bytes[(n-1-i)*8 +: 8];
   endtask

   // pulse start, wait (bounded) for halted/fault, then expect an empty queue
   task automatic run(input string nm, input logic [AW-1:0] sa, input int budget);
      int e0, n;
      e0 = end_cnt;
      n  = 0;
      @(negedge clk);
      startaddr = sa;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (end_cnt == e0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_finished"}, 32'(end_cnt != e0), 32'd1);
      check({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

      // arithmetic, flags, branches, STA/LDA mem, NOPs
      prog(9'h010, 43, {8'h80,8'hF0,8'h81,8'h20,8'h04,8'h01,8'h92,8'h02,8'h01,8'h00,
                        8'h91,8'hFE,8'h03,8'h05,8'h01,8'h03,8'h05,8'h01,8'h92,8'h02,
                        8'h01,8'h88,8'h40,8'h80,8'h00,8'h01,8'h84,8'h40,8'h01,8'h81,
                        8'hD0,8'h05,8'h90,8'h05,8'h01,8'h07,8'h8F,8'h33,8'h00,8'h91,
                        8'hF9,8'h01,8'h00});
      prog(9'h050, 4, {8'h80,8'h5A,8'h01,8'h00});          // OUTA under busy UART
      prog(9'h060, 3, {8'h02,8'h01,8'h00});                // INA, echo
      prog(9'h1FC, 2, {8'h90,8'h04});                      // BRA wraps to 0x002
      prog(9'h002, 4, {8'h80,8'h77,8'h01,8'h00});
      prog(9'h1D0, 7, {8'h80,8'h66,8'h06,8'h94,8'h05,8'h01,8'h00});
      prog(9'h17E, 5, {8'h80,8'h3C,8'h94,8'h10,8'h00});    // nested JSR/RTS
      prog(9'h192, 4, {8'h94,8'h10,8'h01,8'h06});
      prog(9'h1A4, 1, {8'h06});
      prog(9'h1B0, 6, {8'h94,8'h00,8'h94,8'h00,8'h94,8'h00});
      prog(9'h1C0, 1, {8'h06});
      prog(9'h100, 3, {8'h84,8'h40,8'h00});                // LDA mem, reset in WAIT3
      prog(9'h110, 2, {8'h01,8'h00});

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {write_en, transmit, halted, fault, c_raddr, c_waddr, tx_byte},
            32'd0);
      rst = 1'b1;

      // program 1
      push(K_TX, 0, 8'h10);      // ADD F0+20 -> 10, C=1; BRC taken
      push(K_TX, 0, 8'hF0);      // BRZ -2 with Z=0 fell through; SUB 10-20
      push(K_TX, 0, 8'hD0);      // SUB F0-20 after CLF
      push(K_TX, 0, 8'hD0);      // BRC not taken (C=0)
      push(K_WR, 9'h040, 8'hD0); // STA 0x40
      push(K_TX, 0, 8'h00);      // LDA #0
      push(K_TX, 0, 8'hD0);      // LDA 0x40
      push(K_TX, 0, 8'h00);      // SUB -> 0, Z=1, BRZ -7 taken backwards
      push(K_HLT, 0, 8'h00);
      run("prog_alu_branch_mem", 9'h010, 1000);

      // OUTA held off by is_transmitting
      is_transmitting = 1'b1;
      push(K_TX, 0, 8'h5A);
      push(K_HLT, 0, 8'h00);
      n = tx_cnt;
      fork
         run("prog_outa_busy", 9'h050, 300);
         begin
            repeat (30) @(negedge clk);
            check("tx_while_busy", 32'(tx_cnt - n), 32'd0);
            is_transmitting = 1'b0;
         end
      join

      // INA, with an ignored start pulse while waiting in READ
      push(K_TX, 0, 8'hA5);
      push(K_HLT, 0, 8'h00);
      fork
         run("prog_ina", 9'h060, 300);
         begin
            repeat (20) @(negedge clk);
            startaddr = 9'h050;
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (5) @(negedge clk);
            rx_byte  = 8'hA5;
            received = 1'b1;
            @(negedge clk);
            received = 1'b0;
         end
      join

      // BRA at end of memory wraps
      push(K_TX, 0, 8'h77);
      push(K_HLT, 0, 8'h00);
      run("prog_bra_wrap", 9'h1FC, 300);

`ifdef CPU_WIDE_STACK_EN
      push(K_TX, 0, 8'h3C);
      push(K_HLT, 0, 8'h00);
      run("prog_jsr_nested", 9'h17E, 500);
      push(K_FLT, 0, 8'h00);
      run("prog_jsr_overflow", 9'h1B0, 300);
      push(K_FLT, 0, 8'h00);
      run("prog_rts_underflow", 9'h1C0, 300);
`else
      // 06 is a NOP and 94 skips its operand; B=D0 so a stray SUB would show
      push(K_TX, 0, 8'h66);
      push(K_HLT, 0, 8'h00);
      run("prog_stack_nop", 9'h1D0, 300);
`endif

      // reset while LDA mem waits for data
      @(negedge clk);
      startaddr = 9'h100;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (c_raddr !== 9'h040 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("reached_wait3", 32'(c_raddr), 32'h040);
      rst = 1'b0;
      @(negedge clk);
      check("reset_midinstr_outputs", {write_en, transmit, halted, fault, c_raddr}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("after_reset_quiet", {write_en, halted}, 32'd0);
      push(K_TX, 0, 8'h00);      // A was cleared by reset
      push(K_HLT, 0, 8'h00);
      run("prog_after_reset", 9'h110, 300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
